// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the digit-scan sequencer
//
// Holds the scan FSM state type and the position/select widths used by
// scan_seq and scan_next_sel.
package scan_pkg;

    localparam int SCAN_POS   = 8;
    localparam int SCAN_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_next_sel.sv
// rtl/scan_next_sel.sv - combinational rotate-and-priority search for the next enabled position
//
// Ports:
//   cur       in  [2:0]  currently driven position
//   mask      in  [7:0]  position enables, bit i=1 means position i is scanned
//   from_zero in         1: search upward from position 0 (scan start)
//                        0: search upward from cur+1, modulo 8
//   nxt       out [2:0]  first enabled position found
//   wrap      out        search passed position 7 (nxt <= cur); never set when from_zero
module scan_next_sel
    import scan_pkg::*;
(
    input  logic [SCAN_SEL_W-1:0] cur,
    input  logic [SCAN_POS-1:0]   mask,
    input  logic                  from_zero,
    output logic [SCAN_SEL_W-1:0] nxt,
    output logic                  wrap
);

    logic [SCAN_SEL_W-1:0] base;
    logic [SCAN_SEL_W-1:0] idx;

    always_comb begin
        // Starting the search "after 7" makes the from-zero case the same
        // rotate as the normal advance.
        base = from_zero ? SCAN_SEL_W'(SCAN_POS - 1) : cur;
        idx  = base;
        nxt  = base;
        // Walk from the farthest offset down to the nearest so the nearest
        // enabled position overwrites the rest. Offset 8 truncates to base
        // itself, which covers the single-position case.
        for (int i = SCAN_POS; i >= 1; i--) begin
            idx = base + SCAN_SEL_W'(i);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
        wrap = !from_zero && (nxt <= cur);
    end

endmodule

// File: rtl/scan_seq.sv
// rtl/scan_seq.sv - digit-scan sequencer driving a 3-to-8 active-low decoder
//
// Steps through the enabled positions of mask, holding each for div+1 cycles.
// Optional feature macro: SCAN_DEADTIME_EN adds DEAD_CYC blanking cycles
// (enb=1) ahead of every dwell.
//
// Ports:
//   clk        in            rising-edge clock
//   rst_n      in            asynchronous active-low reset
//   run        in            scan enable, level-sensitive
//   mask       in  [7:0]     position enables
//   div        in  [DIV_W-1:0] dwell length minus one, sampled on dwell entry
//   sel        out [2:0]     decoder select
//   enb        out           decoder disable, active-high
//   frame_done out           one-cycle pulse when sel wraps to the first enabled position
module scan_seq
    import scan_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [SCAN_POS-1:0]   mask,
    input  logic [DIV_W-1:0]      div,
    output logic [SCAN_SEL_W-1:0] sel,
    output logic                  enb,
    output logic                  frame_done
);

    // Named empty block that only exists for an out-of-range DEAD_CYC, so a
    // bad setting is visible in the elaborated hierarchy.
    if (DEAD_CYC < 1 || DEAD_CYC > 255) begin : g_dead_cyc_out_of_range
    end

    scan_state_t           state;
    logic [DIV_W-1:0]      dwell_cnt;
    logic [DIV_W-1:0]      div_q;
`ifdef SCAN_DEADTIME_EN
    logic [7:0]            dead_cnt;
`endif

    logic [SCAN_SEL_W-1:0] nxt;
    logic                  wrap;
    logic                  go;

    // Either condition dropping aborts the scan from any active state.
    assign go = run && (mask != '0);

    scan_next_sel u_next_sel (
        .cur       (sel),
        .mask      (mask),
        .from_zero (state == IDLE),
        .nxt       (nxt),
        .wrap      (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            enb        <= 1'b1;
            frame_done <= 1'b0;
            dwell_cnt  <= '0;
            div_q      <= '0;
`ifdef SCAN_DEADTIME_EN
            dead_cnt   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    enb <= 1'b1;
                    if (go) begin
                        sel <= nxt;
`ifdef SCAN_DEADTIME_EN
                        state    <= BLANK;
                        dead_cnt <= '0;
`else
                        state     <= ON;
                        enb       <= 1'b0;
                        dwell_cnt <= '0;
                        div_q     <= div;
`endif
                    end
                end
`ifdef SCAN_DEADTIME_EN
                BLANK: begin
                    if (!go) begin
                        state <= IDLE;
                        enb   <= 1'b1;
                    end else if (dead_cnt == 8'(DEAD_CYC - 1)) begin
                        state     <= ON;
                        enb       <= 1'b0;
                        dwell_cnt <= '0;
                        div_q     <= div;
                    end else begin
                        dead_cnt <= dead_cnt + 8'd1;
                    end
                end
`endif
                ON: begin
                    if (!go) begin
                        state <= IDLE;
                        enb   <= 1'b1;
                    end else if (dwell_cnt == div_q) begin
                        // Equality compare: div all-ones gives 2^DIV_W cycles
                        // without the counter ever overflowing.
                        sel        <= nxt;
                        frame_done <= wrap;
`ifdef SCAN_DEADTIME_EN
                        state    <= BLANK;
                        enb      <= 1'b1;
                        dead_cnt <= '0;
`else
                        dwell_cnt <= '0;
                        div_q     <= div;
`endif
                    end else begin
                        dwell_cnt <= dwell_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    enb   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq.sv
// tb/tb_scan_seq.sv - self-checking bench for scan_seq against a slot-arithmetic reference model
module tb_scan_seq;

    localparam int DIV_W = 4;
    localparam int DEAD  = 4;
`ifdef SCAN_DEADTIME_EN
    localparam int BL = DEAD;
`else
    localparam int BL = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [7:0]       mask = 8'h00;
    logic [DIV_W-1:0] div = '0;
    logic [2:0]       sel;
    logic             enb;
    logic             frame_done;

    int total = 0;
    int bad   = 0;

    int pos_list[$];
    int per;
    int last_sel;

    scan_seq #(.DIV_W(DIV_W), .DEAD_CYC(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
        .div        (div),
        .sel        (sel),
        .enb        (enb),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: every enabled position owns a slot of per = blank + div + 1
    // cycles; cycle k (k=1 is the cycle after run is sampled) lies in slot
    // (k-1)/per at offset (k-1)%per. A frame boundary is the first cycle of
    // every N-th slot after the first.
    task automatic scan(input logic [7:0] m, input int d, input int ncyc, input string tag);
        int s, o, n, es, ee, ef;
        pos_list.delete();
        for (int i = 0; i < 8; i++) if (m[i]) pos_list.push_back(i);
        n    = pos_list.size();
        per  = BL + d + 1;
        mask = m;
        div  = DIV_W'(d);
        run  = 1'b1;
        es   = pos_list[0];
        for (int k = 1; k <= ncyc; k++) begin
            step();
            s  = (k - 1) / per;
            o  = (k - 1) % per;
            es = pos_list[s % n];
            ee = (o < BL) ? 1 : 0;
            ef = (s > 0 && (s % n) == 0 && o == 0) ? 1 : 0;
            chk({tag, ".sel"}, 32'(sel), 32'(es));
            chk({tag, ".enb"}, 32'(enb), 32'(ee));
            chk({tag, ".frame_done"}, 32'(frame_done), 32'(ef));
        end
        last_sel = es;
        run = 1'b0;
        step();
        chk({tag, ".stop_enb"}, 32'(enb), 32'd1);
        chk({tag, ".stop_sel"}, 32'(sel), 32'(last_sel));
        chk({tag, ".stop_fd"}, 32'(frame_done), 32'd0);
        step();
        chk({tag, ".idle_enb"}, 32'(enb), 32'd1);
        chk({tag, ".idle_sel"}, 32'(sel), 32'(last_sel));
    endtask

    initial begin
        logic [7:0] rm;
        int rd, np;

        // Reset held through a few edges, then idle with run=0.
        step();
        step();
        chk("reset.sel", 32'(sel), 32'd0);
        chk("reset.enb", 32'(enb), 32'd1);
        chk("reset.fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle.sel", 32'(sel), 32'd0);
            chk("idle.enb", 32'(enb), 32'd1);
            chk("idle.fd", 32'(frame_done), 32'd0);
        end

        // Full mask, two frames plus a little.
        scan(8'hFF, 2, 2 * 8 * (BL + 3) + 3, "full");
        // Sparse mask 2,5,7.
        scan(8'b1010_0100, 0, 3 * 3 * (BL + 1) + 2, "sparse");
        // Single position, several periods; div=0 exercises back-to-back wraps.
        scan(8'h10, 1, 5 * (BL + 2), "single");
        scan(8'h10, 0, 6 * (BL + 1), "single_d0");
        // Maximum dwell.
        scan(8'h81, 15, 3 * (BL + 16), "maxdiv");
        // Drop run mid-dwell on position 3, then restart from lowest position.
        scan(8'hFF, 2, 3 * (BL + 3) + BL + 2, "drop3");
        chk("drop3.held", 32'(last_sel), 32'd3);
        scan(8'hFF, 2, BL + 2, "restart");

        // Randomized masks and dwells.
        for (int r = 0; r < 6; r++) begin
            rm = 8'($urandom_range(1, 255));
            rd = int'($urandom_range(0, 15));
            np = $countones(rm);
            scan(rm, rd, int'($urandom_range(1, 3 * np * (BL + rd + 1))), "rand");
        end

        // Asynchronous reset mid-blank (mid-dwell without the blanking build).
        mask = 8'hA4;
        div  = DIV_W'(3);
        run  = 1'b1;
        step();
        step();
        chk("arst.pre_sel", 32'(sel), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst.sel", 32'(sel), 32'd0);
        chk("arst.enb", 32'(enb), 32'd1);
        chk("arst.fd", 32'(frame_done), 32'd0);
        run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("arst.after_sel", 32'(sel), 32'd0);
        chk("arst.after_enb", 32'(enb), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
